// File: rtl/sagu_miss_ctl.sv
// rtl/sagu_miss_ctl.sv - store-AGU TLB-miss FIFO, page-walk sequencer and replay/fault reporter
// Optional same-page walk skipping under `define SAGU_MISS_MERGE_EN.
module sagu_miss_ctl #(
  parameter int DEPTH = 4,
  parameter int TMO_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_en,
  input  logic [43:0] miss_addr,
  input  logic [3:0]  miss_attr,
  input  logic [9:0]  miss_ii,
  input  logic        except,
  output logic        stall,
  output logic        walk_req,
  output logic [43:0] walk_addr,
  input  logic        walk_ack,
  input  logic        walk_done,
  input  logic        walk_fault,
  input  logic        issue_idle,
  output logic        mex_en,
  output logic [43:0] mex_addr,
  output logic [3:0]  mex_attr,
  output logic        fault_en,
  output logic [9:0]  fault_ii,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_REPLAY, S_FAULT, S_DRAIN
  } state_t;

  state_t state, state_nx;

  logic [43:0]      addr_mem [DEPTH];
  logic [3:0]       attr_mem [DEPTH];
  logic [9:0]       ii_mem   [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [TMO_W-1:0] timer;
  logic             push, pop, tmo, merge_hit;

  assign tmo       = &timer;
  assign pop       = mex_en | fault_en;
  // A full FIFO still accepts a miss when the head leaves in the same cycle.
  assign push      = miss_en & ~except & ((count != CW'(DEPTH)) | pop);
  assign stall     = (count >= CW'(DEPTH - 1));
  assign busy      = (count != '0) | (state != S_IDLE);
  assign walk_addr = addr_mem[rd_ptr];
  assign mex_addr  = addr_mem[rd_ptr];
  assign mex_attr  = attr_mem[rd_ptr];

`ifdef SAGU_MISS_MERGE_EN
  logic [30:0] last_pg;
  logic        last_pg_v;

  assign merge_hit = last_pg_v & (last_pg == addr_mem[rd_ptr][43:13]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_pg   <= '0;
      last_pg_v <= 1'b0;
    end else if (except) begin
      last_pg_v <= 1'b0;
    end else if (state == S_WAIT) begin
      if (walk_done && !walk_fault) begin
        last_pg   <= addr_mem[rd_ptr][43:13];
        last_pg_v <= 1'b1;
      end else if (walk_done || tmo) begin
        last_pg_v <= 1'b0;
      end
    end
  end
`else
  assign merge_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (except) begin
      // A walk already handed to the walker must still have its completion absorbed.
      if (state == S_WAIT || (state == S_REQ && walk_ack)) state_nx = S_DRAIN;
      else                                                 state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (count != '0) state_nx = merge_hit ? S_REPLAY : S_REQ;
        S_REQ:    if (walk_ack) state_nx = S_WAIT;
        S_WAIT: begin
          if (walk_done)  state_nx = walk_fault ? S_FAULT : S_REPLAY;
          else if (tmo)   state_nx = S_FAULT;
        end
        S_REPLAY: if (mex_en) state_nx = S_IDLE;
        S_FAULT:  state_nx = S_IDLE;
        S_DRAIN:  if (walk_done || tmo) state_nx = S_IDLE;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    walk_req = (state == S_REQ);
    mex_en   = (state == S_REPLAY) & issue_idle & ~except;
    fault_en = (state == S_FAULT) & ~except;
    fault_ii = fault_en ? ii_mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
    end else if (state == S_REQ && walk_ack) begin
      timer <= '0;
    end else if (state == S_WAIT || state == S_DRAIN) begin
      timer <= timer + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        attr_mem[i] <= '0;
        ii_mem[i]   <= '0;
      end
    end else if (except) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        addr_mem[wr_ptr] <= miss_addr;
        attr_mem[wr_ptr] <= miss_attr;
        ii_mem[wr_ptr]   <= miss_ii;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_sagu_miss_ctl.sv
// tb/tb_sagu_miss_ctl.sv - directed and randomized bench for sagu_miss_ctl against a queue-based model
module tb_sagu_miss_ctl;
  localparam int DEPTH   = 4;
  localparam int TMO_W   = 8;
  localparam int TMO_MAX = 1 << TMO_W;
`ifdef SAGU_MISS_MERGE_EN
  localparam bit MERGE_ON = 1'b1;
`else
  localparam bit MERGE_ON = 1'b0;
`endif
  localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_REPLAY = 3, P_FAULT = 4, P_DRAIN = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_en, except, walk_ack, walk_done, walk_fault, issue_idle;
  logic [43:0] miss_addr;
  logic [3:0]  miss_attr;
  logic [9:0]  miss_ii;
  logic        stall, walk_req, mex_en, fault_en, busy;
  logic [43:0] walk_addr, mex_addr;
  logic [3:0]  mex_attr;
  logic [9:0]  fault_ii;

  sagu_miss_ctl #(.DEPTH(DEPTH), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .miss_en(miss_en), .miss_addr(miss_addr), .miss_attr(miss_attr),
    .miss_ii(miss_ii), .except(except), .stall(stall), .walk_req(walk_req), .walk_addr(walk_addr),
    .walk_ack(walk_ack), .walk_done(walk_done), .walk_fault(walk_fault), .issue_idle(issue_idle),
    .mex_en(mex_en), .mex_addr(mex_addr), .mex_attr(mex_attr), .fault_en(fault_en),
    .fault_ii(fault_ii), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [43:0] addr;
    logic [3:0]  attr;
    logic [9:0]  ii;
  } ent_t;

  // Model: pending misses in arrival order, the phase of the current walk, and its age.
  ent_t        mq[$];
  int          ph = P_IDLE;
  int          age = 0;
  bit          lpv = 1'b0;
  logic [30:0] lp = '0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  ent_t head;
  bit   e_req, e_mex, e_flt, e_pop, merge;
  int   nx;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_stall", stall, 0);    chk("rst_busy", busy, 0);
      chk("rst_walk_req", walk_req, 0); chk("rst_mex_en", mex_en, 0);
      chk("rst_fault_en", fault_en, 0); chk("rst_fault_ii", fault_ii, 0);
      chk("rst_walk_addr", walk_addr, 0); chk("rst_mex_addr", mex_addr, 0);
      chk("rst_mex_attr", mex_attr, 0);
      mq.delete(); ph = P_IDLE; age = 0; lpv = 1'b0;
    end else begin
      head  = (mq.size() != 0) ? mq[0] : '0;
      e_req = (ph == P_REQ);
      e_mex = (ph == P_REPLAY) && issue_idle && !except;
      e_flt = (ph == P_FAULT) && !except;
      e_pop = e_mex || e_flt;
      chk("stall", stall, mq.size() >= DEPTH - 1);
      chk("busy", busy, (mq.size() != 0) || (ph != P_IDLE));
      chk("walk_req", walk_req, e_req);
      chk("mex_en", mex_en, e_mex);
      chk("fault_en", fault_en, e_flt);
      chk("fault_ii", fault_ii, e_flt ? head.ii : 10'h0);
      if (e_req) chk("walk_addr", walk_addr, head.addr);
      if (e_mex) begin
        chk("mex_addr", mex_addr, head.addr);
        chk("mex_attr", mex_attr, head.attr);
      end
      if (miss_en && !except && mq.size() == DEPTH && !e_pop) begin
        n_chk++;
        $display("FAIL protocol: miss_en on full queue at %0t", $time);
      end
      if (except) begin
        nx = (ph == P_WAIT || (ph == P_REQ && walk_ack)) ? P_DRAIN : P_IDLE;
        mq.delete();
        lpv = 1'b0;
      end else begin
        nx = ph;
        merge = MERGE_ON && lpv && (mq.size() != 0) && (head.addr[43:13] == lp);
        case (ph)
          P_IDLE:   if (mq.size() != 0) nx = merge ? P_REPLAY : P_REQ;
          P_REQ:    if (walk_ack) nx = P_WAIT;
          P_WAIT: begin
            if (walk_done && !walk_fault) begin nx = P_REPLAY; lpv = 1'b1; lp = head.addr[43:13]; end
            else if (walk_done || age == TMO_MAX - 1) begin nx = P_FAULT; lpv = 1'b0; end
          end
          P_REPLAY: if (e_mex) nx = P_IDLE;
          P_FAULT:  nx = P_IDLE;
          P_DRAIN:  if (walk_done || age == TMO_MAX - 1) nx = P_IDLE;
          default:  nx = P_IDLE;
        endcase
        if (e_pop && mq.size() != 0) void'(mq.pop_front());
        if (miss_en && mq.size() < DEPTH) mq.push_back('{miss_addr, miss_attr, miss_ii});
      end
      if (ph == P_REQ && walk_ack) age = 0;
      else if (ph == P_WAIT || ph == P_DRAIN) age = (age + 1) % TMO_MAX;
      ph = nx;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    miss_en = 1'b0; walk_ack = 1'b0; walk_done = 1'b0; walk_fault = 1'b0; except = 1'b0;
  endtask

  task automatic miss(input logic [43:0] a, input logic [3:0] at, input logic [9:0] ii);
    miss_en = 1'b1; miss_addr = a; miss_attr = at; miss_ii = ii;
  endtask

  task automatic serve_and_check(input string name, input logic [43:0] a0, input logic [43:0] a1,
                                 input logic [43:0] a2);
    logic [43:0] got[$];
    logic [43:0] exp_q[$];
    exp_q = '{a0, a1, a2};
    for (int i = 0; i < 80; i++) begin
      next_cycle();
      walk_ack = 1'b1; walk_done = 1'b1;
      #1;
      if (mex_en) got.push_back(mex_addr);
      if (!busy) break;
    end
    chk({name, "_cnt"}, got.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s_order%0d", name, i), (i < got.size()) ? got[i] : 44'h0, exp_q[i]);
  endtask

  int  fcyc;
  bit  seen;
  logic [43:0] ra;

  initial begin
    rst = 1'b0; miss_en = 1'b0; except = 1'b0; walk_ack = 1'b0; walk_done = 1'b0;
    walk_fault = 1'b0; issue_idle = 1'b1; miss_addr = '0; miss_attr = '0; miss_ii = '0;
    #2;
    chk("init_walk_req", walk_req, 0);
    chk("init_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Basic replay
    next_cycle(); miss(44'h0_1234_5678_0, 4'h2, 10'h011); #1; chk("basic_c0_req", walk_req, 0);
    next_cycle(); #1; chk("basic_c1_req", walk_req, 0); chk("basic_c1_busy", busy, 1);
    next_cycle(); walk_ack = 1'b1; #1;
    chk("basic_c2_req", walk_req, 1); chk("basic_c2_addr", walk_addr, 44'h0_1234_5678_0);
    next_cycle(); #1; chk("basic_c3_req", walk_req, 0);
    next_cycle(); #1; chk("basic_c4_req", walk_req, 0);
    next_cycle(); walk_done = 1'b1; #1; chk("basic_c5_mex", mex_en, 0);
    next_cycle(); #1;
    chk("basic_c6_mex", mex_en, 1); chk("basic_c6_addr", mex_addr, 44'h0_1234_5678_0);
    chk("basic_c6_attr", mex_attr, 4'h2);
    next_cycle(); #1; chk("basic_c7_mex", mex_en, 0); chk("basic_c7_busy", busy, 0);

    // Walk fault
    next_cycle(); miss(44'h0_0abc_0000_0, 4'h5, 10'h155);
    next_cycle();
    next_cycle(); walk_ack = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle(); walk_done = 1'b1; walk_fault = 1'b1;
    next_cycle(); #1;
    chk("fault_en", fault_en, 1); chk("fault_ii", fault_ii, 10'h155); chk("fault_nomex", mex_en, 0);
    next_cycle(); #1; chk("fault_busy", busy, 0); chk("fault_en_off", fault_en, 0);

    // Walk timeout: WAIT entered at c3, timer all-ones at c258, fault at c259
    next_cycle(); miss(44'h0_0fff_0000_0, 4'h1, 10'h2aa);
    next_cycle();
    next_cycle(); walk_ack = 1'b1;
    fcyc = -1;
    for (int c = 3; c <= 270; c++) begin
      next_cycle(); #1;
      if (fault_en && fcyc < 0) fcyc = c;
    end
    chk("tmo_cycle", fcyc, 259);
    chk("tmo_busy", busy, 0);

    // Back-pressure and pointer wrap
    issue_idle = 1'b1;
    next_cycle(); miss(44'h0_0000_000a_0, 4'ha, 10'h00a);
    next_cycle(); miss(44'h0_0000_000b_0, 4'hb, 10'h00b); #1; chk("bp_c1_stall", stall, 0);
    next_cycle(); miss(44'h0_0000_000c_0, 4'hc, 10'h00c); #1; chk("bp_c2_stall", stall, 0);
    next_cycle(); #1; chk("bp_c3_stall", stall, 1);
    serve_and_check("bp_abc", 44'h0_0000_000a_0, 44'h0_0000_000b_0, 44'h0_0000_000c_0);
    next_cycle(); miss(44'h0_0000_000d_0, 4'hd, 10'h00d);
    next_cycle(); miss(44'h0_0000_000e_0, 4'he, 10'h00e);
    next_cycle(); miss(44'h0_0000_000f_0, 4'hf, 10'h00f);
    next_cycle(); #1; chk("wrap_stall", stall, 1);
    serve_and_check("wrap_def", 44'h0_0000_000d_0, 44'h0_0000_000e_0, 44'h0_0000_000f_0);

    // Flush during WAIT with two entries queued
    seen = 1'b0;
    next_cycle(); miss(44'h0_0000_1111_0, 4'h3, 10'h001);
    next_cycle(); miss(44'h0_0000_2222_0, 4'h4, 10'h002);
    next_cycle(); walk_ack = 1'b1;
    next_cycle(); except = 1'b1; #1; seen |= mex_en | fault_en;
    next_cycle(); #1; seen |= mex_en | fault_en;
    chk("flush_busy_drain", busy, 1); chk("flush_stall", stall, 0);
    next_cycle(); #1; seen |= mex_en | fault_en;
    next_cycle(); walk_done = 1'b1; #1; seen |= mex_en | fault_en;
    next_cycle(); #1; seen |= mex_en | fault_en;
    chk("flush_idle", busy, 0);
    chk("flush_no_out", seen, 0);

    // Randomized traffic with an asynchronous reset in the middle
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      if (i == 1500) begin
        rst = 1'b0; #1;
        chk("midrst_busy", busy, 0); chk("midrst_walk_req", walk_req, 0);
        next_cycle(); rst = 1'b1;
      end
      issue_idle = ($urandom_range(0, 9) < 7);
      if (mq.size() < DEPTH && $urandom_range(0, 9) < 3) begin
        ra = {$urandom, $urandom};
        miss(ra, 4'($urandom), 10'($urandom));
      end
      walk_ack   = $urandom_range(0, 1);
      walk_done  = ($urandom_range(0, 99) < 15);
      walk_fault = ($urandom_range(0, 2) == 0);
      except     = ($urandom_range(0, 99) < 3);
    end
    repeat (5) next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
